// File: rtl/sonar.sv
// HC-SR04-style ultrasonic ranger controller: periodic trigger, echo-width
// measurement in microseconds, and conversion to centimetres.
module sonar #(
    parameter int clk_freq   = 125_000_000,
    parameter int trig_us    = 10,
    parameter int period_ms  = 60,
    parameter int timeout_us = 38_000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        trig,
    input  logic        ech,
    output logic [9:0]  distance_cm,
    output logic [15:0] echo_us,
    output logic        valid,
    output logic        timeout
);

    localparam int US_CYC     = clk_freq / 1_000_000;
    localparam int TRIG_CYC   = trig_us * US_CYC;
    localparam int PERIOD_CYC = clk_freq / 1000 * period_ms;
    localparam int CW         = $clog2(PERIOD_CYC);
    localparam int PW         = (US_CYC > 1) ? $clog2(US_CYC) : 1;
    localparam int US_PER_CM  = 58;

    typedef enum logic [1:0] {TRIG, WAIT, MEAS, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] period_cnt;
    logic          wrap;
    logic [2:0]    ech_sync;
    logic          rise;
    logic          fall;
    logic [PW-1:0] presc;
    logic [15:0]   us_cnt;
    logic [5:0]    sub_cnt;
    logic [9:0]    cm_cnt;
    logic          tick;
    logic [15:0]   us_next;
    logic [5:0]    sub_next;
    logic [9:0]    cm_next;
    logic          reached;

    assign wrap = (period_cnt == CW'(PERIOD_CYC - 1));

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
            trig       <= 1'b0;
        end else begin
            period_cnt <= wrap ? '0 : period_cnt + CW'(1);
            trig       <= (period_cnt < CW'(TRIG_CYC));
        end
    end

    // Two flops to resynchronise the echo, a third to detect its edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ech_sync <= '0;
        else     ech_sync <= {ech_sync[1:0], ech};
    end

    assign rise = ech_sync[1] & ~ech_sync[2];
    assign fall = ~ech_sync[1] & ech_sync[2];

    // Counter values after this cycle's microsecond tick, so a falling edge
    // that coincides with a tick still includes that final microsecond.
    always_comb begin
        // NOTE: every signal gets a default before the conditionals, so no
        // path leaves it unassigned and no latch is inferred.
        tick     = (state == MEAS) && (presc == PW'(US_CYC - 1));
        us_next  = us_cnt;
        sub_next = sub_cnt;
        cm_next  = cm_cnt;
        if (tick) begin
            if (us_cnt != '1) us_next = us_cnt + 16'd1;
            if (sub_cnt == 6'(US_PER_CM - 1)) begin
                sub_next = '0;
                if (cm_cnt != '1) cm_next = cm_cnt + 10'd1;
            end else begin
                sub_next = sub_cnt + 6'd1;
            end
        end
        reached = (us_next >= 16'(timeout_us));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= TRIG;
            presc       <= '0;
            us_cnt      <= '0;
            sub_cnt     <= '0;
            cm_cnt      <= '0;
            distance_cm <= '0;
            echo_us     <= '0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                TRIG: begin
                    if (period_cnt == CW'(TRIG_CYC - 1)) state <= WAIT;
                end
                WAIT: begin
                    if (wrap) begin
                        timeout <= 1'b1;
                        valid   <= 1'b1;
                        state   <= TRIG;
                    end else if (rise) begin
                        presc   <= '0;
                        us_cnt  <= '0;
                        sub_cnt <= '0;
                        cm_cnt  <= '0;
                        state   <= MEAS;
                    end
                end
                MEAS: begin
                    presc   <= tick ? '0 : presc + PW'(1);
                    us_cnt  <= us_next;
                    sub_cnt <= sub_next;
                    cm_cnt  <= cm_next;
                    if (wrap || (!fall && reached)) begin
                        distance_cm <= 10'd1023;
                        echo_us     <= 16'(timeout_us);
                        timeout     <= 1'b1;
                        valid       <= 1'b1;
                        state       <= wrap ? TRIG : HOLD;
                    end else if (fall) begin
                        distance_cm <= cm_next;
                        echo_us     <= us_next;
                        timeout     <= 1'b0;
                        valid       <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (wrap) state <= TRIG;
                end
                default: state <= TRIG;
            endcase
        end
    end

endmodule

// File: tb/tb_sonar.sv
// Bench for sonar: scaled-down timing, directed boundary echoes plus random
// echo widths checked against a floor(us/58) range model.
module tb_sonar;

    localparam int CLK_FREQ   = 2_000_000;
    localparam int TRIG_US    = 10;
    localparam int PERIOD_MS  = 2;
    localparam int TIMEOUT_US = 1500;
    localparam int US_CYC     = CLK_FREQ / 1_000_000;
    localparam int TRIG_CYC   = TRIG_US * US_CYC;
    localparam int PERIOD_CYC = CLK_FREQ / 1000 * PERIOD_MS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ech = 1'b0;
    logic        trig;
    logic [9:0]  distance_cm;
    logic [15:0] echo_us;
    logic        valid;
    logic        timeout;

    sonar #(
        .clk_freq  (CLK_FREQ),
        .trig_us   (TRIG_US),
        .period_ms (PERIOD_MS),
        .timeout_us(TIMEOUT_US)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trig       (trig),
        .ech        (ech),
        .distance_cm(distance_cm),
        .echo_us    (echo_us),
        .valid      (valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Monitor: cycle index since reset release, valid captures, trig rises.
    int          cyc           = 0;
    int          valid_cnt     = 0;
    int          trig_rises    = 0;
    int          last_rise_cyc = 0;
    logic        trig_q        = 1'b0;
    logic [9:0]  v_dist        = '0;
    logic [15:0] v_us          = '0;
    logic        v_to          = 1'b0;
    int          v_cyc         = 0;

    always @(negedge clk) begin
        if (rst) begin
            cyc    <= 0;
            trig_q <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (valid) begin
                valid_cnt <= valid_cnt + 1;
                v_dist    <= distance_cm;
                v_us      <= echo_us;
                v_to      <= timeout;
                v_cyc     <= cyc + 1;
            end
            if (trig && !trig_q) begin
                trig_rises    <= trig_rises + 1;
                last_rise_cyc <= cyc + 1;
            end
            trig_q <= trig;
        end
    end

    // Reference model: the last reported result.
    int model_dist = 0;
    int model_us   = 0;
    int model_tol  = 0;
    int prev_rise  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [31:0] got, input int exp, input int tol);
        vectors++;
        assert (!$isunknown(got) && int'(got) >= exp - tol && int'(got) <= exp + tol) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, got, exp, tol);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_trig_rise(input string tag, input int budget);
        int  base;
        bit  ok;
        base = trig_rises;
        ok   = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            ok = (trig_rises != base);
        end
        vectors++;
        assert (ok) else begin
            miscompares++;
            $error("FAIL %s: observed no trig rise expected one within %0d cycles", tag, budget);
        end
    endtask

    task automatic wait_trig_low();
        int n;
        n = 0;
        while (trig && n < TRIG_CYC + 5) begin
            tick();
            n++;
        end
    endtask

    task automatic check_trig_width(input string tag);
        int n;
        n = trig ? 1 : 0;
        while (trig && n < TRIG_CYC + 10) begin
            tick();
            if (trig) n++;
        end
        check(tag, 32'(n), 32'(TRIG_CYC));
    endtask

    task automatic next_period(input string tag);
        wait_trig_rise(tag, PERIOD_CYC + 20);
        check({tag, "_len"}, 32'(last_rise_cyc - prev_rise), 32'(PERIOD_CYC));
        prev_rise = last_rise_cyc;
    endtask

    // One period: echo of w us starting d cycles after the trigger falls.
    task automatic measure(input int w, input int d);
        int base;
        int exp_to;
        wait_trig_low();
        repeat (d) tick();
        base = valid_cnt;
        ech  = 1'b1;
        repeat (w * US_CYC) tick();
        ech = 1'b0;
        repeat (12) tick();
        check($sformatf("valid_count_w%0d", w), 32'(valid_cnt - base), 32'd1);
        if (w < TIMEOUT_US) begin
            model_dist = (w / 58 > 1023) ? 1023 : w / 58;
            model_us   = w;
            model_tol  = 1;
            exp_to     = 0;
        end else begin
            model_dist = 1023;
            model_us   = TIMEOUT_US;
            model_tol  = 0;
            exp_to     = 1;
        end
        check($sformatf("timeout_w%0d", w), 32'(v_to), 32'(exp_to));
        check($sformatf("distance_w%0d", w), 32'(v_dist), 32'(model_dist));
        check_near($sformatf("echo_us_w%0d", w), 32'(v_us), model_us, model_tol);
        next_period("period");
        check($sformatf("single_valid_w%0d", w), 32'(valid_cnt - base), 32'd1);
        check($sformatf("hold_distance_w%0d", w), 32'(distance_cm), 32'(model_dist));
    endtask

    initial begin
        int base;
        int w;

        // Reset values while rst is held.
        #3;
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_distance", 32'(distance_cm), 32'd0);
        check("rst_echo_us", 32'(echo_us), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Trigger timing from the first edge after release.
        wait_trig_rise("first_trig", 10);
        check("first_trig_cycle", 32'(last_rise_cyc), 32'd1);
        prev_rise = last_rise_cyc;
        check_trig_width("trig_width");

        // No echo in the first period: timeout at the wrap, zeros kept.
        base = valid_cnt;
        for (int i = 0; i < PERIOD_CYC + 10 && valid_cnt == base; i++) tick();
        check("noecho_valid", 32'(valid_cnt - base), 32'd1);
        check_near("noecho_valid_cycle", 32'(v_cyc), PERIOD_CYC, 1);
        check("noecho_timeout", 32'(v_to), 32'd1);
        check("noecho_distance", 32'(v_dist), 32'd0);
        check("noecho_echo_us", 32'(v_us), 32'd0);
        next_period("second_trig");
        check_trig_width("trig_width_2");

        // Nominal and rounding boundaries.
        measure(120, 1);
        measure(57, 4);
        measure(58, 7);
        measure(116, 2);
        measure(1740, 3);

        // Echo activity only inside the trigger window: ignored, then the
        // wrap reports a timeout with the previous distance kept.
        base = valid_cnt;
        for (int i = 0; i < 12; i++) begin
            ech = ~ech;
            tick();
        end
        ech = 1'b0;
        wait_trig_low();
        repeat (5) tick();
        check("trigwin_no_valid", 32'(valid_cnt - base), 32'd0);
        next_period("trigwin_period");
        check("trigwin_valid", 32'(valid_cnt - base), 32'd1);
        check("trigwin_timeout", 32'(v_to), 32'd1);
        check("trigwin_keep_distance", 32'(v_dist), 32'(model_dist));
        check_near("trigwin_keep_echo_us", 32'(v_us), model_us, model_tol);

        // Over-long echo.
        measure(1700, 5);

        // Random echo widths, some beyond the timeout.
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 3) == 0) w = int'($urandom_range(1520, 1800));
            else                           w = int'($urandom_range(1, 1480));
            measure(w, int'($urandom_range(1, 60)));
        end

        // Asynchronous reset in the middle of a measurement.
        wait_trig_low();
        repeat (5) tick();
        ech = 1'b1;
        repeat (50) tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_trig", 32'(trig), 32'd0);
        check("midrst_distance", 32'(distance_cm), 32'd0);
        check("midrst_echo_us", 32'(echo_us), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_timeout", 32'(timeout), 32'd0);
        ech = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        wait_trig_rise("midrst_trig_rise", 10);
        check("midrst_trig_cycle", 32'(last_rise_cyc), 32'd1);
        prev_rise = last_rise_cyc;
        check_trig_width("midrst_trig_width");
        measure(58, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
